// File: rtl/mmio_port_responder_pkg.sv
// Shared definitions for the MMIO port responder:
// register offsets, STATUS bit positions and TX state encoding.
package mmio_port_responder_pkg;

  localparam logic [3:0] OFF_PORT_OUT = 4'h0;
  localparam logic [3:0] OFF_PORT_IN  = 4'h4;
  localparam logic [3:0] OFF_TX_DATA  = 4'h8;
  localparam logic [3:0] OFF_STATUS   = 4'hC;

  localparam int STAT_BUSY = 0;
  localparam int STAT_OVR  = 1;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [1:0] word_of(input logic [3:0] off);
    return off[3:2];
  endfunction

endpackage

// File: rtl/mmio_port_responder_uart_tx_core.sv
// 8N1 serializer: start bit, 8 data bits LSB first, stop bit.
// TxD comes straight from a flop so the line never glitches.
module uart_tx_core
  import mmio_port_responder_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       txd,
  output logic       busy
);

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  tx_state_e   state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  sh, sh_n;
  logic        txd_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= TX_IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      txd   <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
      txd   <= txd_n;
    end
  end

  // txd_n is the line level for the cycle after this edge
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    txd_n   = txd;
    unique case (state)
      TX_IDLE: begin
        txd_n = 1'b1;
        if (start) begin
          sh_n    = data;
          cnt_n   = '0;
          txd_n   = 1'b0;
          state_n = TX_START;
        end
      end
      TX_START: begin
        if (cnt == LAST) begin
          cnt_n   = '0;
          idx_n   = '0;
          txd_n   = sh[0];
          state_n = TX_DATA;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      TX_DATA: begin
        if (cnt == LAST) begin
          cnt_n = '0;
          if (idx == 3'd7) begin
            idx_n   = '0;
            txd_n   = 1'b1;
            state_n = TX_STOP;
          end else begin
            idx_n = idx + 3'd1;
            sh_n  = {1'b0, sh[7:1]};
            txd_n = sh[1];
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      TX_STOP: begin
        if (cnt == LAST) begin
          cnt_n   = '0;
          state_n = TX_IDLE;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      default: state_n = TX_IDLE;
    endcase
  end

  assign busy = (state != TX_IDLE);

endmodule

// File: rtl/mmio_port_responder.sv
// Memory-mapped GPIO + UART transmitter window on the MEM stage bus.
// Loads are combinational; stores land on the rising edge.
module mmio_port_responder
  import mmio_port_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0100,
  parameter int          CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Hit,
  input  logic [7:0]  PortIn,
  output logic [31:0] PortOut,
  output logic        TxD,
  output logic        TxBusy
);

  logic [7:0]  sync1, sync2;
  logic        overrun;
  logic        wr;
  logic        sel_out, sel_in, sel_tx, sel_st;
  logic        tx_start, ovr_set, ovr_clr;
  logic [31:0] status;
  logic        unused;

  assign unused = ^Address[1:0];

  assign Hit     = (Address[31:4] == BASE_ADDR[31:4]);
  assign wr      = MemWrite & Hit;
  assign sel_out = (Address[3:2] == word_of(OFF_PORT_OUT));
  assign sel_in  = (Address[3:2] == word_of(OFF_PORT_IN));
  assign sel_tx  = (Address[3:2] == word_of(OFF_TX_DATA));
  assign sel_st  = (Address[3:2] == word_of(OFF_STATUS));

  assign tx_start = wr & sel_tx & ~TxBusy;
  assign ovr_set  = wr & sel_tx & TxBusy;
  assign ovr_clr  = wr & sel_st & WriteData[STAT_OVR];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PortOut <= '0;
      sync1   <= '0;
      sync2   <= '0;
      overrun <= 1'b0;
    end else begin
      sync1 <= PortIn;
      sync2 <= sync1;
      if (wr && sel_out)
        PortOut <= WriteData;
      // a new overrun beats a simultaneous clear
      if (ovr_set)
        overrun <= 1'b1;
      else if (ovr_clr)
        overrun <= 1'b0;
    end
  end

  always_comb begin
    status            = '0;
    status[STAT_BUSY] = TxBusy;
    status[STAT_OVR]  = overrun;
  end

  always_comb begin
    ReadData = '0;
    if (MemRead && Hit) begin
      unique case (1'b1)
        sel_out: ReadData = PortOut;
        sel_in:  ReadData = {24'b0, sync2};
        sel_tx:  ReadData = '0;
        sel_st:  ReadData = status;
        default: ReadData = '0;
      endcase
    end
  end

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk   (clk),
    .reset (reset),
    .start (tx_start),
    .data  (WriteData[7:0]),
    .txd   (TxD),
    .busy  (TxBusy)
  );

endmodule
